// File: rtl/binning_frame_ctrl_if.sv
// Video timing bundle observed by the binning frame controller: the stream entering the
// binning filter (_i) and the stream leaving it (_o). Same polarities on both sides.
interface binning_frame_ctrl_if;
  logic de_i;
  logic hs_i;
  logic vs_i;
  logic de_o;
  logic hs_o;
  logic vs_o;

  modport master (output de_i, hs_i, vs_i, de_o, hs_o, vs_o);
  modport slave  (input  de_i, hs_i, vs_i, de_o, hs_o, vs_o);
endinterface

// File: rtl/binning_frame_ctrl.sv
// Frame-synchronous controller for the 2x2 binning filter: vblank-only config handoff,
// per-frame sequencing and sticky geometry/timeout error reporting.
module binning_frame_ctrl #(
  parameter int CNT_WIDTH = 16,
  parameter int DRAIN_TMO = 1048576
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_bypass_i,
  input  logic [CNT_WIDTH-1:0] cfg_xsize_i,
  input  logic [CNT_WIDTH-1:0] cfg_ysize_i,
  input  logic                 cfg_apply_i,
  input  logic                 err_clr_i,
  binning_frame_ctrl_if.slave  vid,
  output logic                 bin_bypass_o,
  output logic                 busy_o,
  output logic                 frame_start_o,
  output logic                 frame_done_o,
  output logic [3:0]           err_o,
  output logic [CNT_WIDTH-1:0] frame_cnt_o
);
  localparam int TMO_W = (DRAIN_TMO > 1) ? $clog2(DRAIN_TMO) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(32'd1);
  localparam logic [TMO_W-1:0]     TMO_ZERO = {TMO_W{1'b0}};
  localparam logic [TMO_W-1:0]     TMO_ONE  = TMO_W'(32'd1);
  localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(DRAIN_TMO - 1);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_IN_FRAME   = 2'd2,
    ST_DRAIN      = 2'd3
  } state_t;

  // A saturated counter never equals a legal size, so it is always reported as a mismatch.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    sat_inc = (v == CNT_MAX) ? v : (v + CNT_ONE);
  endfunction

  function automatic logic size_bad(input logic [CNT_WIDTH-1:0] cnt, input logic [CNT_WIDTH-1:0] exp_v);
    size_bad = (cnt != exp_v) || (cnt == CNT_MAX);
  endfunction

  state_t               state_r;
  logic                 vs_i_r, hs_i_r, vs_o_r, hs_o_r;
  logic                 pend_bypass_r, act_bypass_r;
  logic [CNT_WIDTH-1:0] pend_xsize_r, pend_ysize_r, act_xsize_r, act_ysize_r;
  logic [CNT_WIDTH-1:0] in_x_r, in_y_r, out_x_r, out_y_r, frame_cnt_r;
  logic [TMO_W-1:0]     tmr_r;
  logic                 busy_r, frame_start_r, frame_done_r;
  logic [3:0]           err_r;

  logic                 vs_i_rise_s, vs_i_fall_s, hs_i_rise_s, vs_o_fall_s, hs_o_rise_s;
  logic                 out_chk_s, tmo_s, drain_end_s;
  logic [CNT_WIDTH-1:0] exp_ox_s, exp_oy_s;
  logic [3:0]           err_set_s;

  assign vs_i_rise_s = vid.vs_i & ~vs_i_r;
  assign vs_i_fall_s = ~vid.vs_i & vs_i_r;
  assign hs_i_rise_s = vid.hs_i & ~hs_i_r;
  assign vs_o_fall_s = ~vid.vs_o & vs_o_r;
  assign hs_o_rise_s = vid.hs_o & ~hs_o_r;

  assign out_chk_s   = (state_r == ST_IN_FRAME) || (state_r == ST_DRAIN);
  assign tmo_s       = (state_r == ST_DRAIN) && !vs_o_fall_s && (tmr_r == TMO_LAST);
  assign drain_end_s = vs_o_fall_s || (tmr_r == TMO_LAST);
  assign exp_ox_s    = act_bypass_r ? act_xsize_r : {1'b0, act_xsize_r[CNT_WIDTH-1:1]};
  assign exp_oy_s    = act_bypass_r ? act_ysize_r : {1'b0, act_ysize_r[CNT_WIDTH-1:1]};

  // Per-cycle error events; empty lines (zero pixels) are not checked.
  always_comb begin
    err_set_s    = 4'b0000;
    err_set_s[0] = (state_r == ST_IN_FRAME) && hs_i_rise_s && (in_x_r != CNT_ZERO)
                   && size_bad(in_x_r, act_xsize_r);
    err_set_s[1] = (state_r == ST_IN_FRAME) && vs_i_fall_s && size_bad(in_y_r, act_ysize_r);
    err_set_s[2] = out_chk_s && !tmo_s &&
                   ((hs_o_rise_s && (out_x_r != CNT_ZERO) && size_bad(out_x_r, exp_ox_s)) ||
                    ((state_r == ST_DRAIN) && vs_o_fall_s && size_bad(out_y_r, exp_oy_s)));
    err_set_s[3] = tmo_s;
  end

  // Frame FSM, config pending/active handoff, geometry counters and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      vs_i_r        <= 1'b0;
      hs_i_r        <= 1'b0;
      vs_o_r        <= 1'b0;
      hs_o_r        <= 1'b0;
      pend_bypass_r <= 1'b1;
      act_bypass_r  <= 1'b1;
      pend_xsize_r  <= CNT_ZERO;
      pend_ysize_r  <= CNT_ZERO;
      act_xsize_r   <= CNT_ZERO;
      act_ysize_r   <= CNT_ZERO;
      in_x_r        <= CNT_ZERO;
      in_y_r        <= CNT_ZERO;
      out_x_r       <= CNT_ZERO;
      out_y_r       <= CNT_ZERO;
      frame_cnt_r   <= CNT_ZERO;
      tmr_r         <= TMO_ZERO;
      busy_r        <= 1'b0;
      frame_start_r <= 1'b0;
      frame_done_r  <= 1'b0;
      err_r         <= 4'b0000;
    end else begin
      vs_i_r        <= vid.vs_i;
      hs_i_r        <= vid.hs_i;
      vs_o_r        <= vid.vs_o;
      hs_o_r        <= vid.hs_o;
      frame_start_r <= 1'b0;
      frame_done_r  <= 1'b0;
      err_r         <= (err_clr_i ? 4'b0000 : err_r) | err_set_s;

      if (cfg_apply_i) begin
        pend_bypass_r <= cfg_bypass_i;
        pend_xsize_r  <= cfg_xsize_i;
        pend_ysize_r  <= cfg_ysize_i;
      end

      if (state_r == ST_IN_FRAME) begin
        if (hs_i_rise_s && (in_x_r != CNT_ZERO)) begin
          in_x_r <= CNT_ZERO;
          in_y_r <= sat_inc(in_y_r);
        end else if (vid.de_i && !vid.hs_i) begin
          in_x_r <= sat_inc(in_x_r);
        end
      end

      if (out_chk_s) begin
        if (hs_o_rise_s && (out_x_r != CNT_ZERO)) begin
          out_x_r <= CNT_ZERO;
          out_y_r <= sat_inc(out_y_r);
        end else if (vid.de_o && !vid.hs_o) begin
          out_x_r <= sat_inc(out_x_r);
        end
      end

      case (state_r)
        ST_IDLE: begin
          if (cfg_apply_i) state_r <= ST_WAIT_FRAME;
        end
        ST_WAIT_FRAME: begin
          // A rise needs vs_i low on the previous sample, so a frame is never joined mid-way.
          if (vs_i_rise_s) begin
            act_bypass_r  <= pend_bypass_r;
            act_xsize_r   <= pend_xsize_r;
            act_ysize_r   <= pend_ysize_r;
            in_x_r        <= CNT_ZERO;
            in_y_r        <= CNT_ZERO;
            out_x_r       <= CNT_ZERO;
            out_y_r       <= CNT_ZERO;
            busy_r        <= 1'b1;
            frame_start_r <= 1'b1;
            state_r       <= ST_IN_FRAME;
          end
        end
        ST_IN_FRAME: begin
          if (vs_i_fall_s) begin
            tmr_r   <= TMO_ZERO;
            state_r <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_end_s) begin
            busy_r       <= 1'b0;
            frame_done_r <= 1'b1;
            frame_cnt_r  <= frame_cnt_r + CNT_ONE;
            state_r      <= ST_WAIT_FRAME;
          end else begin
            tmr_r <= tmr_r + TMO_ONE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bin_bypass_o  = act_bypass_r;
  assign busy_o        = busy_r;
  assign frame_start_o = frame_start_r;
  assign frame_done_o  = frame_done_r;
  assign err_o         = err_r;
  assign frame_cnt_o   = frame_cnt_r;
endmodule

// File: tb/tb_binning_frame_ctrl.sv
// Directed bench for binning_frame_ctrl: stimulus pushes expected frame-start/frame-done
// responses into queues, a negedge monitor pops and compares when the DUT pulses them.
module tb_binning_frame_ctrl;
  localparam int CW  = 16;
  localparam int TMO = 64;

  typedef struct {
    logic [3:0]  err;
    logic [CW-1:0] cnt;
    int          cyc;
  } done_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_bypass_i;
  logic [CW-1:0] cfg_xsize_i, cfg_ysize_i;
  logic          cfg_apply_i, err_clr_i;
  logic          bin_bypass_o, busy_o, frame_start_o, frame_done_o;
  logic [3:0]    err_o;
  logic [CW-1:0] frame_cnt_o;

  int n_vec = 0;
  int n_mis = 0;
  int cyc   = 0;
  int dummy;
  logic  start_q[$];
  done_t done_q[$];

  binning_frame_ctrl_if vif ();

  binning_frame_ctrl #(.CNT_WIDTH(CW), .DRAIN_TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_bypass_i(cfg_bypass_i), .cfg_xsize_i(cfg_xsize_i), .cfg_ysize_i(cfg_ysize_i),
    .cfg_apply_i(cfg_apply_i), .err_clr_i(err_clr_i), .vid(vif),
    .bin_bypass_o(bin_bypass_o), .busy_o(busy_o), .frame_start_o(frame_start_o),
    .frame_done_o(frame_done_o), .err_o(err_o), .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_bypass"}, {31'd0, bin_bypass_o}, 32'd1);
    chk({tag, "_busy"},   {31'd0, busy_o},       32'd0);
    chk({tag, "_start"},  {31'd0, frame_start_o}, 32'd0);
    chk({tag, "_done"},   {31'd0, frame_done_o}, 32'd0);
    chk({tag, "_err"},    {28'd0, err_o},        32'd0);
    chk({tag, "_cnt"},    {16'd0, frame_cnt_o},  32'd0);
  endtask

  task automatic apply_cfg(input logic byp, input int xs, input int ys);
    cfg_bypass_i = byp;
    cfg_xsize_i  = CW'(xs);
    cfg_ysize_i  = CW'(ys);
    cfg_apply_i  = 1'b1;
    tick();
    cfg_apply_i  = 1'b0;
  endtask

  task automatic push_done(input logic [3:0] e, input int c, input int at_cyc);
    done_t d;
    d.err = e;
    d.cnt = CW'(c);
    d.cyc = at_cyc;
    done_q.push_back(d);
  endtask

  // apply_at: -1 none, 0 together with the vs_i rise, k at the start of line k.
  task automatic in_line(input int px);
    vif.hs_i = 1'b0;
    for (int p = 0; p < px; p++) begin
      vif.de_i = 1'b1;
      tick();
      cfg_apply_i = 1'b0;
    end
    vif.de_i = 1'b0;
    cfg_apply_i = 1'b0;
    tick();
    vif.hs_i = 1'b1;
    tick();
    tick();
  endtask

  task automatic in_frame(input int lines, input int px, input int last_px, input int apply_at,
                          output int fall_cyc);
    vif.vs_i    = 1'b1;
    cfg_apply_i = (apply_at == 0);
    tick();
    cfg_apply_i = 1'b0;
    tick();
    for (int l = 0; l < lines; l++) begin
      cfg_apply_i = (apply_at == l + 1);
      in_line((l == lines - 1) ? last_px : px);
    end
    vif.vs_i = 1'b0;
    fall_cyc = cyc;
    tick();
    tick();
  endtask

  task automatic out_frame(input int lines, input int px);
    vif.vs_o = 1'b1;
    tick();
    tick();
    for (int l = 0; l < lines; l++) begin
      vif.hs_o = 1'b0;
      for (int p = 0; p < px; p++) begin
        vif.de_o = 1'b1;
        tick();
      end
      vif.de_o = 1'b0;
      tick();
      vif.hs_o = 1'b1;
      tick();
      tick();
    end
    vif.vs_o = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic clear_err(input string tag);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    chk(tag, {28'd0, err_o}, 32'd0);
  endtask

  // Monitor: every frame_start/frame_done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_start_o) begin
        if (start_q.size() == 0) begin
          n_vec++;
          n_mis++;
          $display("FAIL unexpected_frame_start: got pulse expected none (t=%0t)", $time);
        end else begin
          chk("start_bypass", {31'd0, bin_bypass_o}, {31'd0, start_q.pop_front()});
          chk("start_busy", {31'd0, busy_o}, 32'd1);
        end
      end
      if (frame_done_o) begin
        if (done_q.size() == 0) begin
          n_vec++;
          n_mis++;
          $display("FAIL unexpected_frame_done: got pulse expected none (t=%0t)", $time);
        end else begin
          done_t d;
          d = done_q.pop_front();
          chk("done_err", {28'd0, err_o}, {28'd0, d.err});
          chk("done_cnt", {16'd0, frame_cnt_o}, {16'd0, d.cnt});
          chk("done_busy", {31'd0, busy_o}, 32'd0);
          if (d.cyc >= 0) chk("done_cycle", cyc, d.cyc);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    cfg_bypass_i = 1'b0; cfg_xsize_i = 16'd0; cfg_ysize_i = 16'd0;
    cfg_apply_i = 1'b0; err_clr_i = 1'b0;
    vif.de_i = 1'b0; vif.hs_i = 1'b1; vif.vs_i = 1'b0;
    vif.de_o = 1'b0; vif.hs_o = 1'b1; vif.vs_o = 1'b0;
    tick();
    tick();
    check_reset("rst_hold");
    rst_n = 1'b1;
    tick();
    check_reset("rst_rel");

    // Binned 8x4 frame, output 4x2.
    apply_cfg(1'b0, 8, 4);
    start_q.push_back(1'b0);
    in_frame(4, 8, 8, -1, dummy);
    push_done(4'h0, 1, -1);
    out_frame(2, 4);

    // Bypass requested mid-frame takes effect only at the following frame start.
    start_q.push_back(1'b0);
    cfg_bypass_i = 1'b1; cfg_xsize_i = 16'd8; cfg_ysize_i = 16'd4;
    in_frame(4, 8, 8, 2, dummy);
    chk("bypass_held_midframe", {31'd0, bin_bypass_o}, 32'd0);
    push_done(4'h0, 2, -1);
    out_frame(2, 4);
    start_q.push_back(1'b1);
    in_frame(4, 8, 8, -1, dummy);
    push_done(4'h0, 3, -1);
    out_frame(4, 8);

    // Short last line (7 px) and only 3 lines: line-length and line-count errors.
    start_q.push_back(1'b1);
    in_frame(3, 8, 7, -1, dummy);
    push_done(4'h3, 4, -1);
    out_frame(4, 8);
    clear_err("err_clear_geom");

    // vs_o held high: drain timeout exactly TMO cycles after the vs_i fall.
    start_q.push_back(1'b1);
    vif.vs_o = 1'b1;
    begin
      int fc;
      in_frame(4, 8, 8, -1, fc);
      push_done(4'h8, 5, fc + TMO + 1);
    end
    repeat (TMO + 8) tick();
    chk("timeout_idle_busy", {31'd0, busy_o}, 32'd0);
    vif.vs_o = 1'b0;
    tick();
    clear_err("err_clear_tmo");

    // Apply coincident with vs_i rise: old pending (bypass) now, new (binned) next frame.
    start_q.push_back(1'b1);
    cfg_bypass_i = 1'b0; cfg_xsize_i = 16'd8; cfg_ysize_i = 16'd4;
    in_frame(4, 8, 8, 0, dummy);
    push_done(4'h0, 6, -1);
    out_frame(4, 8);
    start_q.push_back(1'b0);
    in_frame(4, 8, 8, -1, dummy);
    push_done(4'h0, 7, -1);
    out_frame(2, 4);

    // Reset in the middle of a frame, released with vs_i still high.
    start_q.push_back(1'b0);
    vif.vs_i = 1'b1;
    tick();
    tick();
    in_line(8);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_reset("rst_midframe");
    apply_cfg(1'b0, 8, 4);
    in_line(8);
    in_line(8);
    vif.vs_i = 1'b0;
    tick();
    tick();
    tick();
    chk("no_start_midframe_busy", {31'd0, busy_o}, 32'd0);
    chk("no_err_after_abort", {28'd0, err_o}, 32'd0);
    chk("bypass_after_abort", {31'd0, bin_bypass_o}, 32'd1);
    start_q.push_back(1'b0);
    in_frame(4, 8, 8, -1, dummy);
    push_done(4'h0, 1, -1);
    out_frame(2, 4);
    tick();
    tick();

    chk("start_queue_empty", start_q.size(), 32'd0);
    chk("done_queue_empty", done_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
